// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operation request and result bundle for the mult/div unit
interface mult_div_unit_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed 32x32 multiply (radix-2 Booth) and restoring divide
module mult_div_unit (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [32:0] acc;
    logic [31:0] qreg;
    logic [31:0] m;
    logic        q_1;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        zero_div;

    logic [32:0] booth_sum;
    logic [32:0] shifted;
    logic [31:0] trial;
    logic        fits;

    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // acc carries one guard bit so subtracting 0x80000000 cannot overflow
    always_comb begin
        booth_sum = acc;
        case ({qreg[0], q_1})
            2'b01:   booth_sum = acc + {m[31], m};
            2'b10:   booth_sum = acc - {m[31], m};
            default: booth_sum = acc;
        endcase
        shifted = {acc[31:0], qreg[31]};
        trial   = shifted[31:0] - m;
        fits    = (shifted >= {1'b0, m});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= 6'd0;
            acc          <= 33'd0;
            qreg         <= 32'd0;
            m            <= 32'd0;
            q_1          <= 1'b0;
            is_div       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            zero_div     <= 1'b0;
            bus.hi       <= 32'd0;
            bus.lo       <= 32'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count    <= 6'd0;
                        acc      <= 33'd0;
                        q_1      <= 1'b0;
                        is_div   <= bus.op;
                        bus.busy <= 1'b1;
                        if (bus.op) begin
                            qreg     <= mag(bus.a);
                            m        <= mag(bus.b);
                            neg_q    <= bus.a[31] ^ bus.b[31];
                            neg_r    <= bus.a[31];
                            zero_div <= (bus.b == 32'd0);
                            state    <= DIV;
                        end else begin
                            qreg     <= bus.b;
                            m        <= bus.a;
                            neg_q    <= 1'b0;
                            neg_r    <= 1'b0;
                            zero_div <= 1'b0;
                            state    <= MULT;
                        end
                    end
                end
                MULT: begin
                    {acc, qreg, q_1} <= {booth_sum[32], booth_sum, qreg};
                    count <= count + 6'd1;
                    if (count == 6'd31) state <= FIX;
                end
                DIV: begin
                    if (zero_div) begin
                        bus.done     <= 1'b1;
                        bus.div_zero <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        acc   <= fits ? {1'b0, trial} : {1'b0, shifted[31:0]};
                        qreg  <= {qreg[30:0], fits};
                        count <= count + 6'd1;
                        if (count == 6'd31) state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        bus.lo <= neg_q ? (32'd0 - qreg) : qreg;
                        bus.hi <= neg_r ? (32'd0 - acc[31:0]) : acc[31:0];
                    end else begin
                        bus.lo <= qreg;
                        bus.hi <= acc[31:0];
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    mult_div_unit_if bus();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
                check("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
                check("busy_at_done", {63'd0, bus.busy}, 64'd0);
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input int lat, input bit push);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        if (push) exp_q.push_back('{ehi, elo, edz, cyc + lat});
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        check("busy_after_start", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        n_cmp++;
        n_err++;
        $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
        exp_q.delete();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (bus.done === 1'b1) return;
            @(negedge clk);
        end
        n_cmp++;
        n_err++;
        $display("FAIL done_timeout: got no done expected done within 100 cycles");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        #2 reset = 1'b0;
        #1;
        check("reset_hi", {32'd0, bus.hi}, 64'd0);
        check("reset_lo", {32'd0, bus.lo}, 64'd0);
        check("reset_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b1);
        wait_idle();

        issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33, 1'b1);
        wait_done();
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, 1'b1);
        wait_idle();
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33, 1'b1);
        wait_idle();

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b1);
        wait_idle();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33, 1'b1);
        wait_idle();
        issue(1'b1, 32'd100, 32'd0, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1, 1, 1'b1);
        wait_idle();
        issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1);
        wait_idle();
        issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b0, 33, 1'b1);
        wait_idle();

        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 1'b1);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        issue(1'b1, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 33, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 1'b1);
        wait_idle();

        repeat (40) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
